// File: rtl/mem_arbiter.sv
// mem_arbiter: arbitrates ic/dc requests onto one memory port and routes
// out-of-order responses back to their owner via an ID ownership table.
module mem_arbiter #(
  parameter int PA_WIDTH = 32,
  parameter int REG_WIDTH = 32,
  parameter int LINE_WIDTH = 128,
  parameter int ID_WIDTH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_ic_enable,
  input  logic [PA_WIDTH-1:0]   i_ic_addr,
  input  logic                  i_ic_ack,
  input  logic                  i_dc_enable,
  input  logic [PA_WIDTH-1:0]   i_dc_addr,
  input  logic [REG_WIDTH-1:0]  i_dc_data,
  input  logic                  i_dc_write,
  input  logic                  i_dc_ack,
  output logic                  o_ic_grant,
  output logic                  o_dc_grant,
  output logic [ID_WIDTH-1:0]   o_id_request,
  output logic                  o_ic_resp_enable,
  output logic                  o_dc_resp_enable,
  output logic [LINE_WIDTH-1:0] o_resp_data,
  output logic [ID_WIDTH-1:0]   o_resp_id,
  output logic                  o_mem_enable,
  output logic [PA_WIDTH-1:0]   o_mem_addr,
  output logic [REG_WIDTH-1:0]  o_mem_data,
  output logic                  o_mem_write,
  output logic                  o_mem_ack,
  input  logic                  i_mem_enable,
  input  logic [LINE_WIDTH-1:0] i_mem_data,
  input  logic [ID_WIDTH-1:0]   i_mem_id_request,
  input  logic [ID_WIDTH-1:0]   i_mem_id_response,
  output logic [ID_WIDTH:0]     o_outstanding,
  output logic                  o_error
);
  localparam int N_IDS = 2**ID_WIDTH;
  logic [N_IDS-1:0] valid, owner;
  logic last_grant, err, full, grant, hit, dup;
  logic [ID_WIDTH:0] cnt;
  assign full = cnt == (ID_WIDTH+1)'(N_IDS);
  // last_grant=1 means dc went last, so ic wins the next tie
  assign o_ic_grant = !rst && !full && i_ic_enable && (!i_dc_enable || last_grant);
  assign o_dc_grant = !rst && !full && i_dc_enable && (!i_ic_enable || !last_grant);
  assign grant = o_ic_grant || o_dc_grant;
  assign o_id_request = i_mem_id_request;
  assign o_mem_enable = grant;
  assign o_mem_addr = o_ic_grant ? i_ic_addr : o_dc_grant ? i_dc_addr : '0;
  assign o_mem_data = o_dc_grant ? i_dc_data : '0;
  assign o_mem_write = o_dc_grant && i_dc_write;
  assign o_mem_ack = i_ic_ack | i_dc_ack;
  assign hit = !rst && i_mem_enable && valid[i_mem_id_response];
  assign o_ic_resp_enable = hit && !owner[i_mem_id_response];
  assign o_dc_resp_enable = hit && owner[i_mem_id_response];
  assign o_resp_data = i_mem_data;
  assign o_resp_id = i_mem_id_response;
  // an ID freed and reissued in the same cycle is a legal reuse, not a collision
  assign dup = grant && valid[i_mem_id_request] && !(hit && i_mem_id_response == i_mem_id_request);
  assign o_outstanding = cnt;
  assign o_error = err;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= '0;
      owner <= '0;
      last_grant <= 1'b1;
      cnt <= '0;
      err <= 1'b0;
    end else begin
      err <= (i_mem_enable && !valid[i_mem_id_response]) || dup;
      if (hit) valid[i_mem_id_response] <= 1'b0;
      if (grant) begin
        valid[i_mem_id_request] <= 1'b1;
        owner[i_mem_id_request] <= o_dc_grant;
        last_grant <= o_dc_grant;
      end
      cnt <= cnt + (ID_WIDTH+1)'(grant && !dup) - (ID_WIDTH+1)'(hit);
    end
  end
endmodule
